adc_psctl_axil_resp: RTL and testbench

- AXI4-Lite slave responder that terminates transactions issued by the adc_psctl M00_AXI initiator. It is the far end of the same write-then-read-back protocol.
- Holds NUM_REGS 32-bit read/write control registers.
- Write and read channels are independent. Flat register contents are exported to fabric logic (ADC control, power-stage settings).
- Sits between the AXI interconnect and the ADC/power-stage control datapath.

---
 rtl/adc_psctl_axil_resp.sv | 218 +++++++++++++++++++++
 tb/tb_adc_psctl_axil_resp.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_psctl_axil_resp.sv
// AXI4-Lite slave terminating adc_psctl M00_AXI traffic; NUM_REGS read/write control registers.
// Optional ADC_PSCTL_WR_PULSE_EN adds REG_WR_PULSE, a one-cycle strobe per OKAY register write.
module adc_psctl_axil_resp #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS           = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0]          REG_OUT
`ifdef ADC_PSCTL_WR_PULSE_EN
  ,
  output logic [NUM_REGS-1:0]             REG_WR_PULSE
`endif
);

  localparam int unsigned IdxW  = C_S_AXI_ADDR_WIDTH - 2;
  localparam int unsigned StrbW = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  // StWInit keeps the readys low for the first edge after reset release.
  typedef enum logic [2:0] {
    StWInit,
    StWIdle,
    StWHaveAw,
    StWHaveW,
    StWResp
  } wr_state_e;

  wr_state_e wr_state_q, wr_state_d;

  logic [IdxW-1:0]               aw_idx_q, aw_idx_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [StrbW-1:0]              wstrb_q, wstrb_d;
  logic [1:0]                    bresp_q, bresp_d;
  logic [31:0]                   regs_q [NUM_REGS];
  logic [31:0]                   regs_d [NUM_REGS];

  logic                          arready_q, arready_d;
  logic                          rvalid_q, rvalid_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                    rresp_q, rresp_d;

  logic                          aw_hs, w_hs, ar_hs;
  logic                          wr_commit;
  logic [IdxW-1:0]               wr_idx, ar_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] wr_data, rd_sel;
  logic [StrbW-1:0]              wr_strb;
  logic                          wr_ok, rd_ok;

  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = (wr_state_q == StWIdle) || (wr_state_q == StWHaveW);
  assign S_AXI_WREADY  = (wr_state_q == StWIdle) || (wr_state_q == StWHaveAw);
  assign S_AXI_BVALID  = (wr_state_q == StWResp);
  assign S_AXI_BRESP   = bresp_q;

  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & arready_q;

  // Whichever half arrived first comes from its latch, the other straight off the bus.
  assign wr_idx  = (wr_state_q == StWHaveAw) ? aw_idx_q : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_data = (wr_state_q == StWHaveW) ? wdata_q : S_AXI_WDATA;
  assign wr_strb = (wr_state_q == StWHaveW) ? wstrb_q : S_AXI_WSTRB;
  assign wr_ok   = 32'(wr_idx) < NUM_REGS;

  assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_ok  = 32'(ar_idx) < NUM_REGS;

  always_comb begin
    wr_state_d = wr_state_q;
    aw_idx_d   = aw_idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wr_commit  = 1'b0;
    unique case (wr_state_q)
      StWInit: wr_state_d = StWIdle;
      StWIdle: begin
        if (aw_hs && w_hs) begin
          wr_commit = 1'b1;
        end else if (aw_hs) begin
          wr_state_d = StWHaveAw;
          aw_idx_d   = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
        end else if (w_hs) begin
          wr_state_d = StWHaveW;
          wdata_d    = S_AXI_WDATA;
          wstrb_d    = S_AXI_WSTRB;
        end
      end
      StWHaveAw: wr_commit = w_hs;
      StWHaveW:  wr_commit = aw_hs;
      StWResp: begin
        if (S_AXI_BREADY) wr_state_d = StWIdle;
      end
      default: wr_state_d = StWIdle;
    endcase
    if (wr_commit) wr_state_d = StWResp;
  end

  always_comb begin
    bresp_d = bresp_q;
    regs_d  = regs_q;
    if (wr_commit) begin
      bresp_d = wr_ok ? RespOkay : RespSlvErr;
      for (int k = 0; k < NUM_REGS; k++) begin
        if (wr_idx == IdxW'(k)) begin
          for (int b = 0; b < StrbW; b++) begin
            if (wr_strb[b]) regs_d[k][8*b +: 8] = wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  // Reads sample regs_q, so a same-edge write is not yet visible.
  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (ar_idx == IdxW'(k)) rd_sel = regs_q[k];
    end
  end

  always_comb begin
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    if (ar_hs) begin
      arready_d = 1'b0;
      rvalid_d  = 1'b1;
      rdata_d   = rd_sel;
      rresp_d   = rd_ok ? RespOkay : RespSlvErr;
    end else if (rvalid_q) begin
      if (S_AXI_RREADY) begin
        rvalid_d  = 1'b0;
        arready_d = 1'b1;
      end
    end else begin
      arready_d = 1'b1;
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      wr_state_q <= StWInit;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= '0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      aw_idx_q   <= aw_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      regs_q     <= regs_d;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_out
    assign REG_OUT[32*k +: 32] = regs_q[k];
  end

`ifdef ADC_PSCTL_WR_PULSE_EN
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;

  always_comb begin
    wr_pulse_d = '0;
    if (wr_commit && wr_ok) begin
      for (int k = 0; k < NUM_REGS; k++) wr_pulse_d[k] = (wr_idx == IdxW'(k));
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) wr_pulse_q <= '0;
    else              wr_pulse_q <= wr_pulse_d;
  end

  assign REG_WR_PULSE = wr_pulse_q;
`endif

endmodule

// File: tb/tb_adc_psctl_axil_resp.sv
// Bench for adc_psctl_axil_resp: directed plan items plus randomized traffic against a
// byte-lane register model; REG_WR_PULSE is checked when ADC_PSCTL_WR_PULSE_EN is defined.
module tb_adc_psctl_axil_resp;
  localparam int NR = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [NR*32-1:0] reg_out;
`ifdef ADC_PSCTL_WR_PULSE_EN
  logic [NR-1:0] wr_pulse;
`endif

  int total = 0, passed = 0, failed = 0;
  logic [31:0] mregs [NR];

  always #5 clk = ~clk;

  adc_psctl_axil_resp dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (rst),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .REG_OUT       (reg_out)
`ifdef ADC_PSCTL_WR_PULSE_EN
    ,
    .REG_WR_PULSE  (wr_pulse)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: index is the byte address divided by 4; out-of-range gives SLVERR.
  function automatic logic [1:0] m_write(input logic [4:0] addr, input logic [31:0] data,
                                         input logic [3:0] strb);
    int idx = int'(addr) / 4;
    logic [31:0] mask = 32'h0;
    if (idx >= NR) return 2'b10;
    for (int b = 0; b < 4; b++) if (strb[b]) mask = mask | (32'hFF << (8 * b));
    mregs[idx] = (mregs[idx] & ~mask) | (data & mask);
    return 2'b00;
  endfunction

  function automatic logic [63:0] m_read(input logic [4:0] addr);
    int idx = int'(addr) / 4;
    if (idx >= NR) return {30'h0, 2'b10, 32'h0};
    return {30'h0, 2'b00, mregs[idx]};
  endfunction

  function automatic logic [NR*32-1:0] m_regout();
    logic [NR*32-1:0] v = '0;
    for (int k = 0; k < NR; k++) v[32*k +: 32] = mregs[k];
    return v;
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    logic [1:0] eresp;
    logic [3:0] epulse;
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int cyc = 0;
    eresp  = m_write(addr, data, strb);
    epulse = (eresp == 2'b00) ? (4'b0001 << (int'(addr) / 4)) : 4'b0000;
    while (!(aw_done && w_done) && cyc < 40) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      awaddr  = addr;
      wvalid  = !w_done && (cyc >= w_dly);
      wdata   = data;
      wstrb   = strb;
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      if (aw_done) chk("awready_after_aw", awready, 1'b0);
      if (w_done)  chk("wready_after_w", wready, 1'b0);
      @(posedge clk); #1;
      aw_done = aw_done || aw_hs;
      w_done  = w_done || w_hs;
      cyc++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    chk("wr_handshakes", {aw_done, w_done}, 2'b11);
    chk("bvalid_set", bvalid, 1'b1);
    chk("bresp", bresp, eresp);
`ifdef ADC_PSCTL_WR_PULSE_EN
    chk("wr_pulse", wr_pulse, epulse);
`endif
    for (int i = 0; i < b_dly; i++) begin
      @(negedge clk);
      chk("bvalid_hold", bvalid, 1'b1);
      chk("bresp_hold", bresp, eresp);
      chk("no_aw_during_b", {awready, wready}, 2'b00);
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(negedge clk);
    chk("bvalid_at_accept", bvalid, 1'b1);
    @(posedge clk); #1;
    bready = 1'b0;
    chk("bvalid_clear", bvalid, 1'b0);
    chk("wr_readys_back", {awready, wready}, 2'b11);
`ifdef ADC_PSCTL_WR_PULSE_EN
    chk("wr_pulse_clear", wr_pulse, 4'b0000);
`endif
  endtask

  task automatic do_read(input logic [4:0] addr, input int r_dly);
    logic [63:0] e;
    bit done = 0;
    int cyc = 0;
    e = m_read(addr);
    while (!done && cyc < 40) begin
      arvalid = 1'b1;
      araddr  = addr;
      @(negedge clk);
      done = arready;
      @(posedge clk); #1;
      cyc++;
    end
    arvalid = 1'b0;
    chk("ar_handshake", done, 1'b1);
    chk("rvalid_set", rvalid, 1'b1);
    chk("rdata", rdata, e[31:0]);
    chk("rresp", rresp, e[33:32]);
    for (int i = 0; i < r_dly; i++) begin
      @(negedge clk);
      chk("rvalid_hold", rvalid, 1'b1);
      chk("rdata_hold", {rresp, rdata}, e[33:0]);
      chk("no_ar_during_r", arready, 1'b0);
      @(posedge clk); #1;
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    chk("rvalid_clear", rvalid, 1'b0);
    chk("arready_back", arready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] old0;
    rst = 1'b1;
    {awaddr, araddr, awprot, arprot} = '0;
    {awvalid, wvalid, bready, arvalid, rready} = '0;
    wdata = '0;
    wstrb = '0;
    for (int k = 0; k < NR; k++) mregs[k] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_readys", {awready, wready, arready}, 3'b000);
    chk("rst_valids", {bvalid, rvalid}, 2'b00);
    chk("rst_resps", {bresp, rresp, rdata}, 36'h0);
    chk("rst_regout", reg_out, 128'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("readys_before_first_edge", {awready, wready, arready}, 3'b000);
    @(posedge clk); #1;
    chk("readys_after_first_edge", {awready, wready, arready}, 3'b111);

    // Basic write/readback of all four registers.
    for (int k = 0; k < NR; k++) do_write(5'(4 * k), 32'(k + 1), 4'hF, 0, 0, 0);
    for (int k = 0; k < NR; k++) do_read(5'(4 * k), 0);
    chk("regout_1234", reg_out, 128'h00000004_00000003_00000002_00000001);

    // Split AW/W ordering, both directions.
    do_write(5'h08, 32'hDEADBEEF, 4'hF, 0, 3, 0);
    do_read(5'h08, 0);
    do_write(5'h08, 32'h0, 4'hF, 0, 0, 0);
    do_write(5'h08, 32'hDEADBEEF, 4'hF, 3, 0, 0);
    chk("reg2_deadbeef", reg_out[95:64], 32'hDEADBEEF);

    // Partial strobes and the all-zero strobe.
    do_write(5'h04, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    do_write(5'h04, 32'h12345678, 4'b0101, 1, 0, 0);
    do_read(5'h04, 0);
    chk("reg1_strobe", reg_out[63:32], 32'hFF34FF78);
    do_write(5'h05, 32'h0, 4'b0000, 0, 0, 0);
    chk("strb0_noop", reg_out, m_regout());

    // Out-of-range index.
    do_write(5'h10, 32'h55AA55AA, 4'hF, 0, 0, 0);
    do_read(5'h10, 0);
    do_read(5'h1F, 0);
    chk("slverr_regs_unchanged", reg_out, m_regout());

    // Back-pressure on B and R.
    do_write(5'h0C, 32'hCAFEF00D, 4'hF, 0, 0, 5);
    do_read(5'h0C, 5);

    // Same-edge read and write of reg0 returns the old value.
    old0 = mregs[0];
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    awaddr = 5'h00; araddr = 5'h00; wdata = 32'h13579BDF; wstrb = 4'hF;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("rw_same_edge_rdata", rdata, old0);
    chk("rw_same_edge_valids", {bvalid, rvalid}, 2'b11);
    void'(m_write(5'h00, 32'h13579BDF, 4'hF));
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;
    do_read(5'h00, 0);

    // Reset while holding an address with no data.
    awvalid = 1'b1; awaddr = 5'h04;
    @(posedge clk); #1;
    awvalid = 1'b0;
    chk("have_aw_awready", {awready, wready}, 2'b01);
    rst = 1'b1;
    for (int k = 0; k < NR; k++) mregs[k] = '0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_mid_bvalid", bvalid, 1'b0);
      chk("rst_mid_regout", reg_out, 128'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_readys", {awready, wready, arready}, 3'b111);
    do_write(5'h00, 32'h000000A5, 4'hF, 0, 0, 0);
    chk("post_rst_reg0", reg_out, 128'h000000A5);

    // Randomized traffic against the model.
    for (int n = 0; n < 40; n++) begin
      do_write(5'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      do_read(5'($urandom_range(0, 31)), $urandom_range(0, 2));
      chk("rand_regout", reg_out, m_regout());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
